dep_mult_scheduler: RTL and testbench

Round-robin scheduler that shares one registered DOM GF(2^2) dependent multiplier (`DepMultiplier`) among `NREQ` masked-datapath requesters. Each requester can be, for example, an S-box nibble inverter or a MixColumns lane. The block:
- arbitrates requests;
- drives the multiplier's shared operand ports and fresh-randomness ports `Z0`/`Z1`;
- tracks in-flight operations through the multiplier latency;
- returns the two output shares tagged with the requester id.

---
 rtl/dep_mult_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dep_mult_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dep_mult_scheduler.sv
// Round-robin scheduler sharing one registered DOM GF(2^2) dependent multiplier.
// Ports: req/req_* in, gnt/m_* out, m_aq/m_bq in, rsp_* out; define DEP_SCHED_EXT_RAND_EN for rnd_z0/rnd_z1.
module dep_mult_scheduler #(
  parameter int          NREQ      = 4,
  parameter int          MUL_LAT   = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_ax,
  input  logic [2*NREQ-1:0] req_ay,
  input  logic [2*NREQ-1:0] req_bx,
  input  logic [2*NREQ-1:0] req_by,
`ifdef DEP_SCHED_EXT_RAND_EN
  input  logic [1:0]        rnd_z0,
  input  logic [1:0]        rnd_z1,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        m_ax,
  output logic [1:0]        m_ay,
  output logic [1:0]        m_bx,
  output logic [1:0]        m_by,
  output logic [1:0]        m_z0,
  output logic [1:0]        m_z1,
  input  logic [1:0]        m_aq,
  input  logic [1:0]        m_bq,
  output logic              rsp_valid,
  output logic [2:0]        rsp_id,
  output logic [1:0]        rsp_aq,
  output logic [1:0]        rsp_bq
);

  logic [2:0]      ptr;
  logic [7:0]      elig;
  logic [3:0]      cand;
  logic            found;
  logic [2:0]      win;
  logic [1:0]      sel_ax, sel_ay;
  logic [1:0]      sel_bx, sel_by;
  logic [NREQ-1:0] gnt_nxt;
  logic [1:0]      z0, z1;

  logic [MUL_LAT:0]      tag_v;
  logic [MUL_LAT:0][2:0] tag_id;

  // A request whose grant is currently high was consumed this cycle.
  always_comb begin
    elig  = 8'(req & ~gnt);
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 4'(ptr) + 4'(k);
      if (cand >= 4'(NREQ))
        cand = cand - 4'(NREQ);
      if (!found && elig[cand[2:0]]) begin
        found = 1'b1;
        win   = cand[2:0];
      end
    end
  end

  always_comb begin
    sel_ax  = '0;
    sel_ay  = '0;
    sel_bx  = '0;
    sel_by  = '0;
    gnt_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_nxt[i] = found && (win == 3'(i));
      if (win == 3'(i)) begin
        sel_ax = req_ax[2*i +: 2];
        sel_ay = req_ay[2*i +: 2];
        sel_bx = req_bx[2*i +: 2];
        sel_by = req_by[2*i +: 2];
      end
    end
  end

`ifdef DEP_SCHED_EXT_RAND_EN
  assign z0 = rnd_z0;
  assign z1 = rnd_z1;
`else
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr;
  logic        fb;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign z0 = lfsr[1:0];
  assign z1 = lfsr[3:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lfsr <= SEED;
    else if (found)
      lfsr <= {fb, lfsr[15:1]};
  end
`endif

  // Idle cycles zero the operand ports so no stale share lingers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt  <= '0;
      m_ax <= '0;
      m_ay <= '0;
      m_bx <= '0;
      m_by <= '0;
      m_z0 <= '0;
      m_z1 <= '0;
      ptr  <= 3'(NREQ - 1);
    end else if (found) begin
      gnt  <= gnt_nxt;
      m_ax <= sel_ax;
      m_ay <= sel_ay;
      m_bx <= sel_bx;
      m_by <= sel_by;
      m_z0 <= z0;
      m_z1 <= z1;
      ptr  <= win;
    end else begin
      gnt  <= '0;
      m_ax <= '0;
      m_ay <= '0;
      m_bx <= '0;
      m_by <= '0;
      m_z0 <= '0;
      m_z1 <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[MUL_LAT-1:0], found};
      tag_id <= {tag_id[MUL_LAT-1:0], win};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_aq    <= '0;
      rsp_bq    <= '0;
    end else begin
      rsp_valid <= tag_v[MUL_LAT];
      if (tag_v[MUL_LAT]) begin
        rsp_id <= tag_id[MUL_LAT];
        rsp_aq <= m_aq;
        rsp_bq <= m_bq;
      end
    end
  end

endmodule

// File: tb/tb_dep_mult_scheduler.sv
// Scoreboard bench for dep_mult_scheduler with a GF(4) multiplier stand-in.
// Random and directed requester traffic checked against a behavioural model.
module tb_dep_mult_scheduler;

  localparam int          NREQ    = 4;
  localparam int          MUL_LAT = 1;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_ax, req_ay, req_bx, req_by;
  logic [1:0]        rnd_z0, rnd_z1;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        m_ax, m_ay, m_bx, m_by, m_z0, m_z1;
  logic [1:0]        m_aq, m_bq;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [1:0]        rsp_aq, rsp_bq;

  always #5 clk = ~clk;

  dep_mult_scheduler #(
    .NREQ(NREQ), .MUL_LAT(MUL_LAT), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_ax(req_ax), .req_ay(req_ay),
    .req_bx(req_bx), .req_by(req_by),
`ifdef DEP_SCHED_EXT_RAND_EN
    .rnd_z0(rnd_z0), .rnd_z1(rnd_z1),
`endif
    .gnt(gnt),
    .m_ax(m_ax), .m_ay(m_ay), .m_bx(m_bx), .m_by(m_by),
    .m_z0(m_z0), .m_z1(m_z1),
    .m_aq(m_aq), .m_bq(m_bq),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_aq(rsp_aq), .rsp_bq(rsp_bq)
  );

  // GF(4) product, field polynomial x^2+x+1 (2=x, 3=x+1).
  function automatic logic [1:0] gmul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd0 || b == 2'd0) return 2'd0;
    if (a == 2'd1) return b;
    if (b == 2'd1) return a;
    if (a == b) return (a == 2'd2) ? 2'd3 : 2'd2;
    return 2'd1;
  endfunction

  // Multiplier stand-in: MUL_LAT registers, output shares masked by Z.
  logic [1:0] pa [MUL_LAT];
  logic [1:0] pb [MUL_LAT];
  always @(posedge clk) begin
    pa[0] <= m_z0 ^ m_z1;
    pb[0] <= gmul(m_ax ^ m_ay, m_bx ^ m_by) ^ m_z0 ^ m_z1;
    for (int j = 1; j < MUL_LAT; j++) begin
      pa[j] <= pa[j-1];
      pb[j] <= pb[j-1];
    end
  end
  assign m_aq = pa[MUL_LAT-1];
  assign m_bq = pb[MUL_LAT-1];

  typedef struct {
    int         id;
    logic [1:0] p;
  } exp_t;

  exp_t            sbq[$];
  int              checks = 0;
  int              errors = 0;
  int              mptr;
  logic [NREQ-1:0] mgnt;
  logic [15:0]     mlfsr;
  logic [NREQ-1:0] rq;
  logic [1:0]      oax[NREQ], oay[NREQ], obx[NREQ], oby[NREQ];

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic b;
    b = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | (16'(b) << 15);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mptr  = NREQ - 1;
    mgnt  = '0;
    mlfsr = SEED;
    sbq.delete();
  endtask

  task automatic newop(input int i);
    oax[i] = 2'($urandom);
    oay[i] = 2'($urandom);
    obx[i] = 2'($urandom);
    oby[i] = 2'($urandom);
  endtask

  task automatic drive_inputs();
    req = rq;
    for (int i = 0; i < NREQ; i++) begin
      req_ax[2*i +: 2] = oax[i];
      req_ay[2*i +: 2] = oay[i];
      req_bx[2*i +: 2] = obx[i];
      req_by[2*i +: 2] = oby[i];
    end
    rnd_z0 = 2'($urandom);
    rnd_z1 = 2'($urandom);
  endtask

  // One clock: drive at negedge, predict, check after the edge.
  task automatic cycle(output int win);
    logic [NREQ-1:0] eg, e_gnt;
    logic [7:0]      e_ops;
    logic [3:0]      ez;
    drive_inputs();
    eg  = rq & ~mgnt;
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (win < 0 && eg[i]) win = i;
    end
    e_gnt = '0;
    e_ops = '0;
    ez    = '0;
    if (win >= 0) begin
      e_gnt[win] = 1'b1;
      e_ops = {oax[win], oay[win], obx[win], oby[win]};
`ifdef DEP_SCHED_EXT_RAND_EN
      ez = {rnd_z1, rnd_z0};
`else
      ez    = {mlfsr[3:2], mlfsr[1:0]};
      mlfsr = lfsr_next(mlfsr);
`endif
      mptr = win;
      sbq.push_back('{win, gmul(oax[win] ^ oay[win], obx[win] ^ oby[win])});
    end
    mgnt = e_gnt;
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("m_ops", 32'({m_ax, m_ay, m_bx, m_by}), 32'(e_ops));
    chk("m_z", 32'({m_z1, m_z0}), 32'(ez));
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d expected none", rsp_id);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_prod", 32'(rsp_aq ^ rsp_bq), 32'(e.p));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    int w;
    rq = '0;
    for (int c = 0; c < n; c++) cycle(w);
  endtask

  initial begin
    int w;
    rq = '0;
    for (int i = 0; i < NREQ; i++) newop(i);
    fork
      monitor();
    join_none

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      rq = 4'($urandom);
      drive_inputs();
      @(negedge clk);
      chk("rst_out", 32'({gnt, m_ax, m_ay, m_bx, m_by, m_z0, m_z1,
                          rsp_valid, rsp_id, rsp_aq, rsp_bq}), 32'd0);
    end
    rq = '0;
    drive_inputs();
    model_reset();
    reset = 1'b1;
    idle(4);

    // Single op: 3*3 = 2
    rq[0] = 1'b1;
    oax[0] = 2'b10; oay[0] = 2'b01;
    obx[0] = 2'b01; oby[0] = 2'b10;
    cycle(w);
    chk("single_win", 32'(w), 32'd0);
    idle(4);

    // All requesters held
    rq = '1;
    for (int c = 0; c < 12; c++) begin
      cycle(w);
      if (w >= 0) newop(w);
    end
    idle(3);

    // Lone requester 2 held
    rq = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      cycle(w);
      if (w >= 0) newop(w);
    end
    idle(3);

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      cycle(w);
      for (int i = 0; i < NREQ; i++) begin
        if (i == w) begin
          if ($urandom_range(1) == 1) newop(i);
          else rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(9) < 4) begin
          rq[i] = 1'b1;
          newop(i);
        end
      end
    end
    idle(6);
    chk("drain", 32'(sbq.size()), 32'd0);

    // Reset while an op is in flight
    rq = 4'b0010;
    newop(1);
    cycle(w);
    chk("flight_win", 32'(w), 32'd1);
    rq = '0;
    drive_inputs();
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_rsp", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b1;
    rq = 4'b0011;
    newop(0);
    newop(1);
    cycle(w);
    chk("post_rst_win", 32'(w), 32'd0);
    rq[0] = 1'b0;
    cycle(w);
    idle(6);
    chk("final_drain", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
